// File: rtl/qracc_sram_rw_ctrl.sv
// qracc_sram_rw_ctrl: sequences one SRAM read or write request into a timed
// WL/PCH/WRITE/SAEN pulse train for the analog macro and captures SA_OUT.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rq_valid_i/rq_wr_i       request handshake and direction (1=write)
//   addr_i, wr_data_i        row address and write data
//   rq_ready_o               high only while idle
//   rd_valid_o, rd_data_o    one-cycle read-valid pulse, held read data
//   WL, PCH, WR_DATA, WRITE  registered analog drives (SRAM subset)
//   CSEL, SAEN               registered column select and sense-amp enable
//   SA_OUT                   sense-amp outputs from the macro
module qracc_sram_rw_ctrl #(
  parameter int unsigned numRows    = 128,
  parameter int unsigned numCols    = 32,
  parameter int unsigned PCH_CYCLES = 1,
  parameter int unsigned WL_CYCLES  = 2,
  parameter int unsigned SA_CYCLES  = 1,
  parameter int unsigned WR_CYCLES  = 2,
  localparam int unsigned ADDR_W    = $clog2(numRows)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rq_valid_i,
  input  logic               rq_wr_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [numCols-1:0] wr_data_i,
  output logic               rq_ready_o,
  output logic               rd_valid_o,
  output logic [numCols-1:0] rd_data_o,
  output logic [numRows-1:0] WL,
  output logic               PCH,
  output logic [numCols-1:0] WR_DATA,
  output logic               WRITE,
  output logic [numCols-1:0] CSEL,
  output logic               SAEN,
  input  logic [numCols-1:0] SA_OUT
);

  localparam int unsigned MAX_AB = (PCH_CYCLES > WL_CYCLES) ? PCH_CYCLES : WL_CYCLES;
  localparam int unsigned MAX_CD = (SA_CYCLES > WR_CYCLES) ? SA_CYCLES : WR_CYCLES;
  localparam int unsigned MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W  = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_PCH,
    ST_RWL,
    ST_SENSE,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [numCols-1:0] data_q, data_d;
  logic [numCols-1:0] rd_data_d;
  logic               ready_d, rd_valid_d, pch_d, write_d, saen_d;
  logic [numRows-1:0] wl_d;
  logic [numCols-1:0] wr_data_d, csel_d;
  logic               row_on, in_range;

  // Next state, dwell counter and request latches; outputs are decoded from
  // the next state so every analog pin comes straight off a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_o;

    unique case (state_q)
      ST_IDLE: begin
        if (rq_valid_i) begin
          addr_d = addr_i;
          data_d = wr_data_i;
          if (rq_wr_i) begin
            state_d = ST_WR;
            cnt_d   = CNT_W'(WR_CYCLES - 1);
          end else begin
            state_d = ST_PCH;
            cnt_d   = CNT_W'(PCH_CYCLES - 1);
          end
        end
      end
      ST_WR: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_PCH: begin
        if (cnt_q == '0) begin
          state_d = ST_RWL;
          cnt_d   = CNT_W'(WL_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RWL: begin
        if (cnt_q == '0) begin
          state_d = ST_SENSE;
          cnt_d   = CNT_W'(SA_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SENSE: begin
        if (cnt_q == '0) begin
          state_d   = ST_DONE;
          rd_data_d = SA_OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Out-of-range rows still run the full sequence but never raise a wordline.
    in_range   = (32'(addr_d) < numRows);
    row_on     = (state_d == ST_WR) || (state_d == ST_RWL) || (state_d == ST_SENSE);
    wl_d       = '0;
    if (row_on && in_range) wl_d[addr_d] = 1'b1;

    ready_d    = (state_d == ST_IDLE);
    rd_valid_d = (state_d == ST_DONE);
    pch_d      = (state_d == ST_PCH);
    write_d    = (state_d == ST_WR);
    saen_d     = (state_d == ST_SENSE);
    wr_data_d  = (state_d == ST_WR) ? data_d : '0;
    csel_d     = ((state_d == ST_WR) || (state_d == ST_RWL)) ? '1 : '0;
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rq_ready_o <= 1'b1;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      WL         <= '0;
      PCH        <= 1'b0;
      WR_DATA    <= '0;
      WRITE      <= 1'b0;
      CSEL       <= '0;
      SAEN       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rq_ready_o <= ready_d;
      rd_valid_o <= rd_valid_d;
      rd_data_o  <= rd_data_d;
      WL         <= wl_d;
      PCH        <= pch_d;
      WR_DATA    <= wr_data_d;
      WRITE      <= write_d;
      CSEL       <= csel_d;
      SAEN       <= saen_d;
    end
  end

endmodule

// File: tb/tb_qracc_sram_rw_ctrl.sv
// tb_qracc_sram_rw_ctrl: drives two controller instances (default timing and
// PCH=3/WL=1/SA=2/WR=1) against a timing model derived from the cycle rules
// and a memory scoreboard, with a simple macro model feeding SA_OUT.
module tb_qracc_sram_rw_ctrl;

  logic        clk;
  logic        rst      [2];
  logic        rq_valid [2];
  logic        rq_wr    [2];
  logic [6:0]  addr     [2];
  logic [31:0] wr_data  [2];
  logic        ready    [2];
  logic        rd_valid [2];
  logic [31:0] rd_data  [2];
  logic [127:0] wl      [2];
  logic        pch      [2];
  logic [31:0] wdat     [2];
  logic        write    [2];
  logic [31:0] csel     [2];
  logic        saen     [2];
  logic [31:0] sa_out   [2];

  logic [31:0] macro   [2][128];
  logic [31:0] ref_mem [2][128];
  bit          wrote   [2][128];

  int vectors = 0;
  int miscompares = 0;
  bit inv_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  qracc_sram_rw_ctrl u_a (
    .clk(clk), .rst(rst[0]), .rq_valid_i(rq_valid[0]), .rq_wr_i(rq_wr[0]),
    .addr_i(addr[0]), .wr_data_i(wr_data[0]), .rq_ready_o(ready[0]),
    .rd_valid_o(rd_valid[0]), .rd_data_o(rd_data[0]), .WL(wl[0]), .PCH(pch[0]),
    .WR_DATA(wdat[0]), .WRITE(write[0]), .CSEL(csel[0]), .SAEN(saen[0]),
    .SA_OUT(sa_out[0])
  );

  qracc_sram_rw_ctrl #(.PCH_CYCLES(3), .WL_CYCLES(1), .SA_CYCLES(2), .WR_CYCLES(1)) u_b (
    .clk(clk), .rst(rst[1]), .rq_valid_i(rq_valid[1]), .rq_wr_i(rq_wr[1]),
    .addr_i(addr[1]), .wr_data_i(wr_data[1]), .rq_ready_o(ready[1]),
    .rd_valid_o(rd_valid[1]), .rd_data_o(rd_data[1]), .WL(wl[1]), .PCH(pch[1]),
    .WR_DATA(wdat[1]), .WRITE(write[1]), .CSEL(csel[1]), .SAEN(saen[1]),
    .SA_OUT(sa_out[1])
  );

  function automatic logic [6:0] row_of(input logic [127:0] v);
    row_of = '0;
    for (int i = 0; i < 128; i++) if (v[i]) row_of = 7'(i);
  endfunction

  // Macro model: stores on WRITE, echoes the selected row on the sense amps.
  always @(posedge clk)
    for (int s = 0; s < 2; s++)
      if (write[s] && wl[s] != '0) macro[s][row_of(wl[s])] <= wdat[s];

  always_comb
    for (int s = 0; s < 2; s++)
      sa_out[s] = (wl[s] != '0) ? macro[s][row_of(wl[s])] : 32'h0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Structural invariants on both instances every cycle.
  always @(negedge clk)
    if (inv_en)
      for (int s = 0; s < 2; s++) begin
        check("inv_pch_wl", 128'(pch[s] & (|wl[s])), 128'(0));
        check("inv_write_saen", 128'(write[s] & saen[s]), 128'(0));
        check("inv_onehot_wl", 128'($onehot0(wl[s])), 128'(1));
      end

  task automatic check_reset(input int s);
    check($sformatf("rst_ready%0d", s), 128'(ready[s]), 128'(1));
    check($sformatf("rst_wl%0d", s), wl[s], 128'(0));
    check($sformatf("rst_pch%0d", s), 128'(pch[s]), 128'(0));
    check($sformatf("rst_write%0d", s), 128'(write[s]), 128'(0));
    check($sformatf("rst_saen%0d", s), 128'(saen[s]), 128'(0));
    check($sformatf("rst_csel%0d", s), 128'(csel[s]), 128'(0));
    check($sformatf("rst_wrdata%0d", s), 128'(wdat[s]), 128'(0));
    check($sformatf("rst_rdvalid%0d", s), 128'(rd_valid[s]), 128'(0));
    check($sformatf("rst_rddata%0d", s), 128'(rd_data[s]), 128'(0));
  endtask

  // One request; called at a negedge, returns at the negedge where ready is back.
  task automatic do_op(input int s, input bit w, input logic [6:0] a, input logic [31:0] d);
    int p, wc, sa, wrc, t, n;
    bit in_wr, in_pch, in_wl, in_cs, in_sa, rv;
    logic [127:0] oh;
    p   = (s == 0) ? 1 : 3;
    wc  = (s == 0) ? 2 : 1;
    sa  = (s == 0) ? 1 : 2;
    wrc = (s == 0) ? 2 : 1;
    n = 0;
    while (ready[s] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check($sformatf("ready_wait%0d", s), 128'(ready[s]), 128'(1));
    rq_valid[s] = 1'b1; rq_wr[s] = w; addr[s] = a; wr_data[s] = d;
    if (w) begin ref_mem[s][a] = d; wrote[s][a] = 1'b1; end
    oh = 128'(1) << a;
    t  = w ? 1 + wrc : p + wc + sa + 2;
    @(posedge clk);
    for (int c = 1; c <= t; c++) begin
      @(negedge clk);
      in_wr  = w && c <= wrc;
      in_pch = !w && c <= p;
      in_wl  = !w && c > p && c <= p + wc + sa;
      in_cs  = !w && c > p && c <= p + wc;
      in_sa  = !w && c > p + wc && c <= p + wc + sa;
      rv     = !w && c == p + wc + sa + 1;
      check($sformatf("wl%0d c%0d", s, c), wl[s], (in_wr || in_wl) ? oh : 128'(0));
      check($sformatf("pch%0d c%0d", s, c), 128'(pch[s]), 128'(in_pch));
      check($sformatf("write%0d c%0d", s, c), 128'(write[s]), 128'(in_wr));
      check($sformatf("saen%0d c%0d", s, c), 128'(saen[s]), 128'(in_sa));
      check($sformatf("csel%0d c%0d", s, c), 128'(csel[s]),
            (in_wr || in_cs) ? 128'(32'hFFFF_FFFF) : 128'(0));
      check($sformatf("ready%0d c%0d", s, c), 128'(ready[s]), 128'(c == t));
      check($sformatf("rdvalid%0d c%0d", s, c), 128'(rd_valid[s]), 128'(rv));
      if (in_wr) check($sformatf("wrdata%0d c%0d", s, c), 128'(wdat[s]), 128'(d));
      if (rv || (!w && c == t))
        check($sformatf("rddata%0d a%0d", s, a), 128'(rd_data[s]), 128'(ref_mem[s][a]));
      if (c < t) begin
        rq_valid[s] = 1'($urandom); rq_wr[s] = 1'($urandom);
        addr[s] = 7'($urandom); wr_data[s] = $urandom;
      end else begin
        rq_valid[s] = 1'b0;
      end
    end
  endtask

  task automatic rand_ops(input int s, input int cnt);
    bit w;
    logic [6:0] a;
    for (int i = 0; i < cnt; i++) begin
      w = 1'($urandom);
      a = 7'($urandom);
      if (!w) while (!wrote[s][a]) a = a + 7'd1;
      do_op(s, w, a, $urandom);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; rq_valid[s] = 1'b0; rq_wr[s] = 1'b0;
      addr[s] = '0; wr_data[s] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst[0] = 1'b0; rst[1] = 1'b0;
    inv_en = 1'b1;
    @(negedge clk);

    // Write row 5, read it back through the macro.
    do_op(0, 1'b1, 7'd5, 32'hA5A5_1234);
    do_op(0, 1'b0, 7'd5, 32'h0);

    // Back-to-back writes to the edge rows, then read both.
    do_op(0, 1'b1, 7'd0, $urandom);
    do_op(0, 1'b1, 7'd127, $urandom);
    do_op(0, 1'b0, 7'd0, 32'h0);
    do_op(0, 1'b0, 7'd127, 32'h0);

    rand_ops(0, 24);

    // Reset during the read wordline phase (cycle PCH+1 after accept).
    rq_valid[0] = 1'b1; rq_wr[0] = 1'b0; addr[0] = 7'd5;
    @(posedge clk);
    repeat (2) @(negedge clk);
    check("midrst_wl_before", wl[0], 128'(1) << 5);
    rst[0] = 1'b1; rq_valid[0] = 1'b0;
    @(negedge clk);
    check_reset(0);
    rst[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_rdvalid", 128'(rd_valid[0]), 128'(0));
      check("midrst_no_wl", wl[0], 128'(0));
    end
    do_op(0, 1'b0, 7'd5, 32'h0);

    // Alternate timing instance.
    do_op(1, 1'b1, 7'd9, $urandom);
    do_op(1, 1'b0, 7'd9, 32'h0);
    do_op(1, 1'b1, 7'd127, $urandom);
    do_op(1, 1'b1, 7'd0, $urandom);
    rand_ops(1, 12);

    inv_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
